led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 18 +
 rtl/tick_gen.sv | 39 +++
 rtl/led_sequencer.sv | 109 ++++++++++
 tb/tb_led_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and widths for the LED sequencer: FSM state encoding, LED/speed/position widths.
package led_seq_pkg;

  localparam int LED_W   = 16;
  localparam int SPEED_W = 3;
  localparam int POS_W   = $clog2(LED_W);

  typedef enum logic [1:0] {
    ST_COUNT       = 2'd0,
    ST_SCROLL_UP   = 2'd1,
    ST_SCROLL_DOWN = 2'd2
  } state_t;

  function automatic logic [LED_W-1:0] one_hot(input logic [POS_W-1:0] pos);
    return LED_W'(1) << pos;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Scroll-step timebase: counts i_clk cycles and pulses o_tick once per (SLOW_CLK_PERIOD >> speed) cycles.
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int SLOW_CLK_PERIOD = 6250000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               o_tick
);

  localparam int CNT_W = $clog2(SLOW_CLK_PERIOD + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_W'((SLOW_CLK_PERIOD >> speed) - 1);

  // >= rather than == so a speed increase that shrinks the limit below cnt ticks on the next cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (i_clr || !i_en) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt >= limit) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: 16-bit up/down counter display or bouncing one-hot scroll with 0..SPEED_MAX speeds.
// Define LED_SEQ_SATURATE_EN to make the counter saturate at 0x0000/0xFFFF instead of wrapping.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int SLOW_CLK_PERIOD = 6250000,
  parameter int SPEED_MAX       = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_incr,
  input  logic             i_decr,
  input  logic             i_mode,
  output logic [LED_W-1:0] o_leds,
  output logic [1:0]       o_state,
  output logic             o_tick
);

  state_t             state, state_n;
  logic [LED_W-1:0]   count, count_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [SPEED_W-1:0] speed, speed_n;
  logic               mode_q;
  logic               rise, fall, inc_only, dec_only, scrolling;

  assign rise      = i_mode & ~mode_q;
  assign fall      = ~i_mode & mode_q;
  assign inc_only  = i_incr & ~i_decr;
  assign dec_only  = i_decr & ~i_incr;
  assign scrolling = (state != ST_COUNT);

  tick_gen #(
    .SLOW_CLK_PERIOD(SLOW_CLK_PERIOD)
  ) u_tick_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (scrolling),
    .i_clr (rise | fall),
    .speed (speed),
    .o_tick(o_tick)
  );

  // Mode edges take priority; button pulses in an edge cycle are dropped.
  always_comb begin
    state_n = state;
    count_n = count;
    pos_n   = pos;
    speed_n = speed;
    if (rise) begin
      state_n = ST_SCROLL_UP;
      pos_n   = '0;
    end else if (fall) begin
      state_n = ST_COUNT;
    end else if (!scrolling) begin
`ifdef LED_SEQ_SATURATE_EN
      if (inc_only && count != '1) count_n = count + 1'b1;
      if (dec_only && count != '0) count_n = count - 1'b1;
`else
      if (inc_only) count_n = count + 1'b1;
      if (dec_only) count_n = count - 1'b1;
`endif
    end else begin
      if (inc_only && speed != SPEED_W'(SPEED_MAX)) speed_n = speed + 1'b1;
      if (dec_only && speed != '0)                  speed_n = speed - 1'b1;
      if (o_tick) begin
        case (state)
          ST_SCROLL_UP: begin
            if (pos == POS_W'(LED_W - 1)) begin
              state_n = ST_SCROLL_DOWN;
              pos_n   = POS_W'(LED_W - 2);
            end else begin
              pos_n = pos + 1'b1;
            end
          end
          ST_SCROLL_DOWN: begin
            if (pos == '0) begin
              state_n = ST_SCROLL_UP;
              pos_n   = POS_W'(1);
            end else begin
              pos_n = pos - 1'b1;
            end
          end
          default: state_n = ST_COUNT;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_COUNT;
      count  <= '0;
      pos    <= '0;
      speed  <= '0;
      mode_q <= 1'b0;
      o_leds <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      pos    <= pos_n;
      speed  <= speed_n;
      mode_q <= i_mode;
      o_leds <= (state_n == ST_COUNT) ? count_n : one_hot(pos_n);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed bench for led_sequencer against a bounce-phase reference model.
module tb_led_sequencer;

  localparam int PERIOD = 64;
  localparam int SMAX   = 3;

  logic        clk, rst, incr, decr, mode;
  logic [15:0] o_leds;
  logic [1:0]  o_state;
  logic        o_tick;

  int checks = 0;
  int errors = 0;

  led_sequencer #(
    .SLOW_CLK_PERIOD(PERIOD),
    .SPEED_MAX      (SMAX)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_incr (incr),
    .i_decr (decr),
    .i_mode (mode),
    .o_leds (o_leds),
    .o_state(o_state),
    .o_tick (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scroll position is derived from the number of ticks since scroll entry
  // (a 30-tick bounce cycle), not from an up/down position register.
  logic        m_mode_q, m_scroll, m_tick;
  logic [15:0] m_count;
  int          m_k, m_speed, m_el;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode_q <= 1'b0; m_scroll <= 1'b0; m_tick <= 1'b0;
      m_count <= 16'h0; m_k <= 0; m_speed <= 0; m_el <= 0;
    end else begin
      if ((mode != m_mode_q) || !m_scroll) begin
        m_el <= 0; m_tick <= 1'b0;
      end else if (m_el >= (PERIOD >> m_speed) - 1) begin
        m_el <= 0; m_tick <= 1'b1;
      end else begin
        m_el <= m_el + 1; m_tick <= 1'b0;
      end
      if (mode && !m_mode_q) begin
        m_scroll <= 1'b1; m_k <= 0;
      end else if (!mode && m_mode_q) begin
        m_scroll <= 1'b0;
      end else if (!m_scroll) begin
`ifdef LED_SEQ_SATURATE_EN
        if (incr && !decr && m_count != 16'hFFFF) m_count <= m_count + 16'd1;
        if (decr && !incr && m_count != 16'h0000) m_count <= m_count - 16'd1;
`else
        if (incr && !decr) m_count <= m_count + 16'd1;
        if (decr && !incr) m_count <= m_count - 16'd1;
`endif
      end else begin
        if (incr && !decr && m_speed < SMAX) m_speed <= m_speed + 1;
        if (decr && !incr && m_speed > 0)    m_speed <= m_speed - 1;
        if (m_tick) m_k <= m_k + 1;
      end
      m_mode_q <= mode;
    end
  end

  function automatic int bounce_r();
    return (m_k == 0) ? 0 : ((m_k - 1) % 30) + 1;
  endfunction

  function automatic logic [15:0] exp_leds();
    int r;
    logic [15:0] one;
    one = 16'h1;
    if (!m_scroll) return m_count;
    r = bounce_r();
    return (r <= 15) ? (one << r) : (one << (30 - r));
  endfunction

  function automatic logic [15:0] exp_state();
    if (!m_scroll) return 16'd0;
    return (bounce_r() <= 15) ? 16'd1 : 16'd2;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("leds_model",  o_leds, exp_leds());
    check("state_model", {14'b0, o_state}, exp_state());
    check("tick_model",  {15'b0, o_tick}, {15'b0, m_tick});
  endtask

  task automatic pulse_incr();
    incr = 1'b1; step(); incr = 1'b0;
  endtask

  task automatic pulse_decr();
    decr = 1'b1; step(); decr = 1'b0;
  endtask

  task automatic do_reset(input logic mode_at_release);
    rst = 1'b1; incr = 1'b0; decr = 1'b0; mode = 1'b0;
    step(); step();
    mode = mode_at_release;
    rst = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tick && n < 300);
    if (!o_tick) check("tick_timeout", 16'd0, 16'd1);
  endtask

  task automatic measure_period(output int p);
    int dummy;
    wait_tick(dummy);
    wait_tick(p);
  endtask

  initial begin
    int n, p;
    logic [15:0] exp_wrap;
    rst = 1'b1; incr = 1'b0; decr = 1'b0; mode = 1'b0;

    // Reset state and count wrap/saturation
    do_reset(1'b0);
    step();
    check("reset_leds", o_leds, 16'h0000);
    check("reset_state", {14'b0, o_state}, 16'd0);
    check("reset_tick", {15'b0, o_tick}, 16'd0);
    pulse_decr();
`ifdef LED_SEQ_SATURATE_EN
    exp_wrap = 16'h0000;
`else
    exp_wrap = 16'hFFFF;
`endif
    check("count_wrap", o_leds, exp_wrap);

    // Simultaneous pulses
    do_reset(1'b0);
    repeat (5) pulse_incr();
    check("count_five", o_leds, 16'h0005);
    incr = 1'b1; decr = 1'b1; step(); incr = 1'b0; decr = 1'b0;
    check("simul_pulse", o_leds, 16'h0005);

    // Bounce at speed 0
    do_reset(1'b0);
    step();
    mode = 1'b1;
    step();
    check("scroll_entry_leds", o_leds, 16'h0001);
    check("scroll_entry_state", {14'b0, o_state}, 16'd1);
    for (int i = 1; i <= 17; i++) begin
      wait_tick(n);
      if (i == 1) check("first_tick_delay", 16'(n), 16'd64);
      step();
      if (i == 15) begin
        check("bounce_top_leds", o_leds, 16'h8000);
        check("bounce_top_state", {14'b0, o_state}, 16'd1);
      end
      if (i == 16) begin
        check("bounce_turn_leds", o_leds, 16'h4000);
        check("bounce_turn_state", {14'b0, o_state}, 16'd2);
      end
    end

    // Speed saturation
    measure_period(p);
    check("period_speed0", 16'(p), 16'd64);
    repeat (5) pulse_incr();
    measure_period(p);
    check("period_speed_max", 16'(p), 16'd8);
    repeat (4) pulse_decr();
    measure_period(p);
    check("period_speed_min", 16'(p), 16'd64);

    // Mode retention
    do_reset(1'b0);
    repeat (18) pulse_incr();
    check("count_0x12", o_leds, 16'h0012);
    mode = 1'b1; step();
    pulse_incr(); pulse_incr();
    mode = 1'b0; step();
    check("retain_count", o_leds, 16'h0012);
    check("retain_state", {14'b0, o_state}, 16'd0);
    mode = 1'b1; step();
    measure_period(p);
    check("retain_speed2_period", 16'(p), 16'd16);

    // Reset mid-scroll at pos 9
    n = 0;
    while (o_leds !== 16'h0200 && n < 1000) begin
      step();
      n++;
    end
    check("reach_pos9", o_leds, 16'h0200);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_leds", o_leds, 16'h0000);
    check("async_rst_state", {14'b0, o_state}, 16'd0);
    check("async_rst_tick", {15'b0, o_tick}, 16'd0);
    step();
    rst = 1'b0;
    step();
    check("rst_release_leds", o_leds, 16'h0001);
    check("rst_release_state", {14'b0, o_state}, 16'd1);

    // Randomized traffic checked against the model every cycle
    do_reset(1'b0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 249) == 0) mode = ~mode;
      incr = ($urandom_range(0, 11) == 0);
      decr = ($urandom_range(0, 11) == 0);
      step();
    end
    incr = 1'b0; decr = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
